// File: rtl/seq_select_decoder_pkg.sv
// Shared types and constants for the sequenced one-hot select decoder.
package seq_decoder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_SWEEP  = 1'b1
    } mode_e;

    localparam int PULSE_CNT_W = 4;

endpackage

// File: rtl/seq_select_decoder_if.sv
// Request handshake and decoded-enable bundle between a requester and the decoder.
interface seq_select_decoder_if #(
    parameter int SEL_W = 4
) ();
    localparam int OUT_W = 2 ** SEL_W;

    logic             req_valid;
    logic             req_ready;
    logic             req_mode;
    logic [SEL_W-1:0] req_sel;
    logic [SEL_W-1:0] req_last;
    logic             abort;
    logic [OUT_W-1:0] dec_out;
    logic             dec_valid;
    logic [SEL_W-1:0] dec_index;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_mode, req_sel, req_last, abort,
        input  req_ready, dec_out, dec_valid, dec_index, busy, done
    );

    modport slave (
        input  req_valid, req_mode, req_sel, req_last, abort,
        output req_ready, dec_out, dec_valid, dec_index, busy, done
    );

endinterface

// File: rtl/seq_select_decoder_onehot.sv
// Combinational binary-to-one-hot decoder; the caller registers the result.
module onehot_decoder #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/seq_select_decoder.sv
// Registered one-hot select decoder with single-pulse and contiguous-sweep
// modes; every request ends with one all-zero output cycle.
module seq_select_decoder
    import seq_decoder_pkg::*;
#(
    parameter int SEL_W     = 4,
    parameter int PULSE_LEN = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    seq_select_decoder_if.slave bus
);

    localparam int OUT_W = 2 ** SEL_W;

    if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
        $fatal(1, "seq_select_decoder: SEL_W=%0d outside 1..6", SEL_W);
    end
    if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : g_bad_pulse_len
        $fatal(1, "seq_select_decoder: PULSE_LEN=%0d outside 1..15", PULSE_LEN);
    end

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic [SEL_W-1:0]       cur_q, cur_d;
    logic [SEL_W-1:0]       last_q, last_d;
    logic [SEL_W-1:0]       dec_index_q, dec_index_d;
    logic [PULSE_CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [OUT_W-1:0]       dec_out_q, dec_out_d;
    logic [OUT_W-1:0]       line_onehot;
    logic                   done_q, done_d;
    logic                   transfer;
    logic                   pulse_end;

    assign transfer  = (state_q == ST_IDLE) && bus.req_valid && !bus.abort;
    assign pulse_end = (pulse_cnt_q == PULSE_CNT_W'(PULSE_LEN - 1));

    // Abort has priority over both pulse completion and a new request.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cur_d       = cur_q;
        last_d      = last_q;
        pulse_cnt_d = pulse_cnt_q;
        done_d      = 1'b0;
        dec_index_d = dec_index_q;

        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d     = ST_DRIVE;
                    mode_d      = mode_e'(bus.req_mode);
                    cur_d       = bus.req_sel;
                    last_d      = bus.req_last;
                    pulse_cnt_d = '0;
                end
            end
            ST_DRIVE: begin
                if (bus.abort) begin
                    state_d     = ST_IDLE;
                    pulse_cnt_d = '0;
                end else if (pulse_end) begin
                    pulse_cnt_d = '0;
                    if (mode_q == MODE_SINGLE || cur_q == last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cur_d = cur_q + SEL_W'(1);
                    end
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PULSE_CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pulse_cnt_d = '0;
            end
        endcase

        if (state_d == ST_DRIVE) begin
            dec_index_d = cur_d;
        end
    end

    onehot_decoder #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel    (cur_d),
        .onehot (line_onehot)
    );

    // Decoding the next index lets the enable come straight out of a flop.
    always_comb begin
        dec_out_d = '0;
        if (state_d == ST_DRIVE) begin
            dec_out_d = line_onehot;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_SINGLE;
            cur_q       <= '0;
            last_q      <= '0;
            pulse_cnt_q <= '0;
            dec_out_q   <= '0;
            dec_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            pulse_cnt_q <= pulse_cnt_d;
            dec_out_q   <= dec_out_d;
            dec_index_q <= dec_index_d;
            done_q      <= done_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE) && !bus.abort;
    assign bus.dec_out   = dec_out_q;
    assign bus.dec_valid = |dec_out_q;
    assign bus.dec_index = dec_index_q;
    assign bus.busy      = (state_q == ST_DRIVE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_select_decoder.sv
// Bench for seq_select_decoder: four configurations, each watched every cycle
// against a request-level model, plus directed scenarios on the 4-bit ones.
module tb_seq_select_decoder;

    localparam int N_INST = 4;

    function automatic int cfg_sel_w(input int i);
        case (i)
            0:       return 4;
            1:       return 4;
            2:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int cfg_pulse_len(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic       drv_valid [N_INST];
    logic       drv_mode  [N_INST];
    logic [5:0] drv_sel   [N_INST];
    logic [5:0] drv_last  [N_INST];
    logic       drv_abort [N_INST];

    wire [63:0] obs_out   [N_INST];
    wire [5:0]  obs_index [N_INST];
    wire        obs_valid [N_INST];
    wire        obs_ready [N_INST];
    wire        obs_busy  [N_INST];
    wire        obs_done  [N_INST];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic mode,
                                 input logic [5:0] sel, input logic [5:0] last, input logic abort);
        drv_valid[idx] = valid;
        drv_mode[idx]  = mode;
        drv_sel[idx]   = sel;
        drv_last[idx]  = last;
        drv_abort[idx] = abort;
    endtask

    task automatic wait_cycle();
        @(posedge clock);
        #1;
    endtask

    for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
        localparam int SW = cfg_sel_w(gi);
        localparam int PL = cfg_pulse_len(gi);
        localparam int OW = 2 ** SW;

        seq_select_decoder_if #(.SEL_W(SW)) bus ();

        seq_select_decoder #(
            .SEL_W     (SW),
            .PULSE_LEN (PL)
        ) dut (
            .clock   (clock),
            .reset_n (reset_n),
            .bus     (bus)
        );

        assign bus.req_valid  = drv_valid[gi];
        assign bus.req_mode   = drv_mode[gi];
        assign bus.req_sel    = drv_sel[gi][SW-1:0];
        assign bus.req_last   = drv_last[gi][SW-1:0];
        assign bus.abort      = drv_abort[gi];
        assign obs_out[gi]    = 64'(bus.dec_out);
        assign obs_index[gi]  = 6'(bus.dec_index);
        assign obs_valid[gi]  = bus.dec_valid;
        assign obs_ready[gi]  = bus.req_ready;
        assign obs_busy[gi]   = bus.busy;
        assign obs_done[gi]   = bus.done;

        // Model: an accepted request expands into a per-cycle list of lines;
        // cur is the line shown this cycle, -1 when nothing is driven.
        int cur      = -1;
        int last_idx = 0;
        bit exp_done = 1'b0;
        int plan [$];

        initial begin
            int first_line;
            int n_lines;
            forever begin
                @(posedge clock or negedge reset_n);
                if (!reset_n) begin
                    cur      = -1;
                    last_idx = 0;
                    exp_done = 1'b0;
                    plan.delete();
                end else if (cur >= 0) begin
                    exp_done = 1'b0;
                    if (drv_abort[gi]) begin
                        cur = -1;
                        plan.delete();
                    end else if (plan.size() == 0) begin
                        cur      = -1;
                        exp_done = 1'b1;
                    end else begin
                        cur      = plan.pop_front();
                        last_idx = cur;
                    end
                end else begin
                    exp_done = 1'b0;
                    if (drv_valid[gi] && !drv_abort[gi]) begin
                        first_line = int'(drv_sel[gi]) % OW;
                        n_lines    = drv_mode[gi] ? (((int'(drv_last[gi]) % OW) - first_line + OW) % OW) + 1 : 1;
                        for (int l = 0; l < n_lines; l++) begin
                            for (int p = 0; p < PL; p++) begin
                                plan.push_back((first_line + l) % OW);
                            end
                        end
                        cur      = plan.pop_front();
                        last_idx = cur;
                    end
                end
            end
        end

        initial begin
            string       pfx;
            logic [63:0] exp_out;
            pfx = $sformatf("inst%0d", gi);
            forever begin
                @(negedge clock);
                exp_out = (cur >= 0) ? (64'd1 << cur) : 64'd0;
                checkOutput({pfx, " dec_out"},   obs_out[gi], exp_out);
                checkOutput({pfx, " dec_valid"}, 64'(obs_valid[gi]), 64'(cur >= 0));
                checkOutput({pfx, " busy"},      64'(obs_busy[gi]), 64'(cur >= 0));
                checkOutput({pfx, " dec_index"}, 64'(obs_index[gi]), 64'(last_idx));
                checkOutput({pfx, " done"},      64'(obs_done[gi]), 64'(exp_done));
                checkOutput({pfx, " req_ready"}, 64'(obs_ready[gi]), 64'((cur < 0) && !drv_abort[gi]));
                checkOutput({pfx, " popcount"},  64'($countones(obs_out[gi]) <= 1), 64'd1);
                checkOutput({pfx, " index_vs_out"}, obs_out[gi],
                            obs_valid[gi] ? (64'd1 << obs_index[gi]) : 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] t3_lines [4];
        t3_lines[0] = 64'h4000;
        t3_lines[1] = 64'h8000;
        t3_lines[2] = 64'h0001;
        t3_lines[3] = 64'h0002;

        for (int i = 0; i < N_INST; i++) applyStimulus(i, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);

        #1 reset_n = 1'b0;
        #1;
        checkOutput("reset dec_out", obs_out[0], 64'h0);
        checkOutput("reset busy", 64'(obs_busy[0]), 64'd0);
        checkOutput("reset done", 64'(obs_done[3]), 64'd0);
        checkOutput("reset dec_index", 64'(obs_index[3]), 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2 reset_n = 1'b1;
        wait_cycle();

        $display("[TB] single request, PULSE_LEN=1");
        applyStimulus(0, 1'b1, 1'b0, 6'h5, 6'h0, 1'b0);
        wait_cycle();
        applyStimulus(0, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0);
        checkOutput("single line", obs_out[0], 64'h0020);
        checkOutput("single done_low", 64'(obs_done[0]), 64'd0);
        wait_cycle();
        checkOutput("single zero", obs_out[0], 64'h0);
        checkOutput("single done", 64'(obs_done[0]), 64'd1);
        wait_cycle();
        checkOutput("single done_clear", 64'(obs_done[0]), 64'd0);

        $display("[TB] wrapping sweep E..1, PULSE_LEN=2");
        applyStimulus(1, 1'b1, 1'b1, 6'hE, 6'h1, 1'b0);
        wait_cycle();
        applyStimulus(1, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("sweep line c%0d", c), obs_out[1], t3_lines[c / 2]);
            checkOutput($sformatf("sweep done_low c%0d", c), 64'(obs_done[1]), 64'd0);
            wait_cycle();
        end
        checkOutput("sweep end zero", obs_out[1], 64'h0);
        checkOutput("sweep end done", 64'(obs_done[1]), 64'd1);
        checkOutput("sweep end index", 64'(obs_index[1]), 64'd1);

        $display("[TB] abort on third line of sweep 0..15");
        applyStimulus(0, 1'b1, 1'b1, 6'h0, 6'hF, 1'b0);
        wait_cycle();
        applyStimulus(0, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0);
        checkOutput("abort line0", obs_out[0], 64'h0001);
        wait_cycle();
        checkOutput("abort line1", obs_out[0], 64'h0002);
        wait_cycle();
        checkOutput("abort line2", obs_out[0], 64'h0004);
        applyStimulus(0, 1'b0, 1'b0, 6'h0, 6'h0, 1'b1);
        wait_cycle();
        applyStimulus(0, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0);
        checkOutput("abort zero", obs_out[0], 64'h0);
        checkOutput("abort busy", 64'(obs_busy[0]), 64'd0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("abort no_done", 64'(obs_done[0]), 64'd0);
            wait_cycle();
        end

        applyStimulus(0, 1'b1, 1'b0, 6'h7, 6'h0, 1'b1);
        #1;
        checkOutput("abort_idle ready", 64'(obs_ready[0]), 64'd0);
        wait_cycle();
        applyStimulus(0, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0);
        checkOutput("abort_idle not_accepted", obs_out[0], 64'h0);
        checkOutput("abort_idle busy", 64'(obs_busy[0]), 64'd0);

        $display("[TB] back-to-back singles 3 then 9");
        applyStimulus(0, 1'b1, 1'b0, 6'h3, 6'h0, 1'b0);
        wait_cycle();
        applyStimulus(0, 1'b1, 1'b0, 6'h9, 6'h0, 1'b0);
        checkOutput("b2b first", obs_out[0], 64'h0008);
        wait_cycle();
        checkOutput("b2b gap", obs_out[0], 64'h0);
        checkOutput("b2b gap done", 64'(obs_done[0]), 64'd1);
        wait_cycle();
        applyStimulus(0, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0);
        checkOutput("b2b second", obs_out[0], 64'h0200);
        wait_cycle();
        checkOutput("b2b second done", 64'(obs_done[0]), 64'd1);

        $display("[TB] asynchronous reset in the middle of a sweep");
        applyStimulus(1, 1'b1, 1'b1, 6'h0, 6'hF, 1'b0);
        wait_cycle();
        applyStimulus(1, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0);
        repeat (3) wait_cycle();
        checkOutput("midreset busy_before", 64'(obs_busy[1]), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midreset dec_out", obs_out[1], 64'h0);
        checkOutput("midreset busy", 64'(obs_busy[1]), 64'd0);
        checkOutput("midreset dec_index", 64'(obs_index[1]), 64'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        wait_cycle();

        $display("[TB] randomized traffic on all configurations");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N_INST; i++) begin
                applyStimulus(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              6'($urandom), 6'($urandom), ($urandom_range(0, 19) == 0));
            end
            wait_cycle();
        end
        for (int i = 0; i < N_INST; i++) applyStimulus(i, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        repeat (120) wait_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
